// File: rtl/uart_pkg.sv
// Shared UART definitions: parity codes, receiver FSM states
// and the 3-sample majority vote used at each bit centre.
package uart_pkg;

    localparam logic [1:0] PARITY_NONE = 2'b00;
    localparam logic [1:0] PARITY_EVEN = 2'b01;
    localparam logic [1:0] PARITY_ODD  = 2'b10;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// First-word fall-through ready/valid FIFO; a push is accepted
// while full only when the head is popped in the same cycle.
module uart_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             full, push, pop;

    assign full      = (cnt_q == (AW+1)'(DEPTH));
    assign out_valid = (cnt_q != '0);
    assign in_ready  = !full || out_ready;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = mem_q[rptr_q];

    always_comb begin
        wptr_d = wptr_q + AW'(push);
        rptr_d = rptr_q + AW'(pop);
        cnt_d  = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= in_data;
    end

endmodule

// File: rtl/uart_receiver_framed.sv
// Framed UART receiver: 2-flop sync, majority-voted bit sampling,
// runtime parity/stop selection, tagged RX FIFO and sticky overrun.
module uart_receiver_framed
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int MIN_BDRT   = 9_600,
    parameter int BAUD_BITS  = $clog2((CLOCK_FREQ + (MIN_BDRT / 2) - 1) / (MIN_BDRT / 2)),
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BAUD_BITS-1:0] baud_edge,
    input  logic [1:0]           parity_mode,
    input  logic                 two_stop,
    input  logic                 serial_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_out_perr,
    output logic                 data_out_ferr,
    output logic                 data_out_valid,
    input  logic                 data_out_ready,
    output logic                 overrun,
    input  logic                 overrun_clr,
    output logic                 rx_busy
);

    localparam int EW = DATA_BITS + 2;
    localparam int CW = $clog2(DATA_BITS + 1);

    rx_state_e            state_q, state_d;
    logic                 sync_q, rxd_q;
    logic [BAUD_BITS-1:0] cnt_q, cnt_d;
    logic [CW-1:0]        bitcnt_q, bitcnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 s0_q, s0_d, s1_q, s1_d;
    logic                 perr_q, perr_d, ferr_q, ferr_d;
    logic                 stop2_q, stop2_d;
    logic [1:0]           pmode_q, pmode_d;
    logic                 two_q, two_d;
    logic                 overrun_q, overrun_d;

    logic [BAUD_BITS-1:0] mid;
    logic                 at_m1, at_mid, at_vote, at_edge;
    logic                 vote, par_en, exp_par;
    logic                 push, fifo_ready;
    logic [EW-1:0]        entry, head;

    assign mid     = baud_edge >> 1;
    assign at_m1   = (cnt_q == mid - BAUD_BITS'(1));
    assign at_mid  = (cnt_q == mid);
    assign at_vote = (cnt_q == mid + BAUD_BITS'(1));
    assign at_edge = (cnt_q == baud_edge - BAUD_BITS'(1));
    assign vote    = maj3(s0_q, s1_q, rxd_q);
    assign par_en  = (pmode_q == PARITY_EVEN) || (pmode_q == PARITY_ODD);
    assign exp_par = (pmode_q == PARITY_ODD) ? ~^shift_q : ^shift_q;
    // The final stop vote is folded in directly since the entry is
    // written in the same cycle the vote is taken.
    assign entry   = {ferr_q | ~vote, perr_q, shift_q};

    always_comb begin
        state_d  = state_q;
        cnt_d    = at_edge ? '0 : cnt_q + BAUD_BITS'(1);
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        s0_d     = at_m1 ? rxd_q : s0_q;
        s1_d     = at_mid ? rxd_q : s1_q;
        perr_d   = perr_q;
        ferr_d   = ferr_q;
        stop2_d  = stop2_q;
        pmode_d  = pmode_q;
        two_d    = two_q;
        push     = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (!rxd_q) begin
                    state_d  = RX_START;
                    pmode_d  = parity_mode;
                    two_d    = two_stop;
                    perr_d   = 1'b0;
                    ferr_d   = 1'b0;
                    stop2_d  = 1'b0;
                    bitcnt_d = '0;
                end
            end
            RX_START: begin
                if (at_vote && vote) begin
                    state_d = RX_IDLE;
                    cnt_d   = '0;
                end else if (at_edge) begin
                    state_d = RX_DATA;
                end
            end
            RX_DATA: begin
                if (at_vote) begin
                    shift_d  = {vote, shift_q[DATA_BITS-1:1]};
                    bitcnt_d = bitcnt_q + CW'(1);
                end
                if (at_edge && bitcnt_q == CW'(DATA_BITS)) begin
                    state_d = par_en ? RX_PARITY : RX_STOP;
                end
            end
            RX_PARITY: begin
                if (at_vote) perr_d = vote ^ exp_par;
                if (at_edge) state_d = RX_STOP;
            end
            RX_STOP: begin
                if (at_vote) begin
                    if (!vote) ferr_d = 1'b1;
                    if (two_q && !stop2_q) begin
                        stop2_d = 1'b1;
                    end else begin
                        push    = 1'b1;
                        state_d = RX_IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = RX_IDLE;
                cnt_d   = '0;
            end
        endcase
        overrun_d = (push && !fifo_ready) || (overrun_q && !overrun_clr);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q    <= 1'b1;
            rxd_q     <= 1'b1;
            state_q   <= RX_IDLE;
            cnt_q     <= '0;
            bitcnt_q  <= '0;
            shift_q   <= '0;
            s0_q      <= 1'b1;
            s1_q      <= 1'b1;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            stop2_q   <= 1'b0;
            pmode_q   <= PARITY_NONE;
            two_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            sync_q    <= serial_in;
            rxd_q     <= sync_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bitcnt_q  <= bitcnt_d;
            shift_q   <= shift_d;
            s0_q      <= s0_d;
            s1_q      <= s1_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            stop2_q   <= stop2_d;
            pmode_q   <= pmode_d;
            two_q     <= two_d;
            overrun_q <= overrun_d;
        end
    end

    uart_fifo #(
        .WIDTH(EW),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .in_valid (push),
        .in_data  (entry),
        .in_ready (fifo_ready),
        .out_valid(data_out_valid),
        .out_data (head),
        .out_ready(data_out_ready)
    );

    assign data_out      = head[DATA_BITS-1:0];
    assign data_out_perr = head[DATA_BITS];
    assign data_out_ferr = head[DATA_BITS+1];
    assign overrun       = overrun_q;
    assign rx_busy       = (state_q != RX_IDLE);

endmodule
